// File: rtl/regfile.sv
// regfile: 32x32 MIPS register file, $0 hardwired to zero, same-cycle write-through to both read ports
module regfile #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);
   logic [DATA_W-1:0] regs [NUM_REGS];
   always_ff @(posedge clk)
      if (!rst)
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      else if (we && waddr != '0)
         regs[waddr] <= wdata;
   always_comb begin
      rdata1 = (!rst || raddr1 == '0 || !re1) ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
      rdata2 = (!rst || raddr2 == '0 || !re2) ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
   end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Serves the two operand read requests issued by the decode stage and accepts one register write-back per cycle from the write-back stage.
- Register $0 is hardwired to zero.
- A same-cycle write is forwarded to the read ports, so decode sees the value being written back without a stall.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-low (0 = reset)
- we  input  1  write enable from write-back stage
- waddr  input  ADDR_W  destination register of the write
- wdata  input  DATA_W  value to write
- re1  input  1  read enable, port 1 (from decode)
- raddr1  input  ADDR_W  source register, port 1
- rdata1  output  DATA_W  read data, port 1
- re2  input  1  read enable, port 2 (from decode)
- raddr2  input  ADDR_W  source register, port 2
- rdata2  output  DATA_W  read data, port 2

Behaviour:

Reset:
- When rst=0 at a rising clk edge, all NUM_REGS registers are cleared to 0 on that edge.
- A write presented in the same cycle is discarded; reset has priority.
- While rst=0, rdata1 and rdata2 are forced to 0, combinationally.

Write path:
- On a rising edge with rst=1, we=1 and waddr!=0: reg[waddr] <= wdata.
- A write with waddr=0 is ignored; reg[0] always reads 0.
- we=0 leaves all registers unchanged.
- Write latency is 1 cycle: a read in the following cycle returns the new value from storage.

Read path (purely combinational, zero latency), evaluated per port n in priority order:
1. rst=0 -> rdata_n = 0
2. raddr_n=0 -> rdata_n = 0 (independent of re_n)
3. re_n=0 -> rdata_n = 0
4. we=1 and waddr=raddr_n -> rdata_n = wdata (write-through bypass)
5. otherwise -> rdata_n = reg[raddr_n]

Port independence and simultaneous events:
- Both ports are fully independent and may read the same address in the same cycle; both return identical data.
- Both ports may match a concurrent write; both are bypassed.
- A write to $0 is never bypassed, since rule 2 wins.

Reset deasserted mid-operation:
- The first cycle with rst=1 accepts writes normally.
- Reads in that cycle return 0 from storage, or the bypassed wdata if the address matches.

Structural constraints:
- No other state is held; there are no handshakes, stalls or back-pressure.
- The block never blocks the pipeline.
- Outputs have no X: every path resolves to a defined value.
- The bypass compare is a full ADDR_W-bit equality.
- The storage array is NUM_REGS entries; entry 0 may be omitted by synthesis.

Test Plan:
1. Reset clear: preload reg[5]=0x12345678; hold rst=0 one edge; release; re1=1,raddr1=5 -> rdata1=0x00000000. During rst=0 with re1=1,raddr1=5 -> rdata1=0.
2. Basic write/read: we=1,waddr=3,wdata=0xDEADBEEF at edge N; cycle N+1 re1=1,raddr1=3 and re2=1,raddr2=3 -> rdata1=rdata2=0xDEADBEEF.
3. $0 protection: we=1,waddr=0,wdata=0xFFFFFFFF; same cycle re1=1,raddr1=0 -> rdata1=0, no bypass; next cycle rdata1=0.
4. Bypass: reg[7]=0x00000011; cycle with we=1,waddr=7,wdata=0x00000022 and re1=1,raddr1=7, re2=1,raddr2=8 -> rdata1=0x22 same cycle, rdata2=reg[8]; next cycle raddr1=7 -> 0x22.
5. Read enable gating: reg[9]=0xA5A5A5A5; re2=0,raddr2=9 -> rdata2=0. Same cycle we=1,waddr=9,wdata=0x1 -> rdata2 still 0.
6. Reset vs write collision: rst=0 and we=1,waddr=4,wdata=0x55 on the same edge; release rst; raddr1=4,re1=1 -> rdata1=0. Then sweep-write all registers 1..31 with value=index and read back via both ports -> each returns its index.
